button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 119 +++++++++++
 tb/tb_button_conditioner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Debounces a synchronized push-button level and derives press/release pulses,
// a long-hold flag and an auto-repeat pulse train while the button stays down.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 100_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_sync,
    output logic btn_level,
    output logic press_p,
    output logic release_p,
    output logic repeat_p,
    output logic long_hold
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
    localparam int unsigned RepW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    // One counter serves both the hold phase and the repeat phase.
    localparam int unsigned HW    = (HoldW > RepW) ? HoldW : RepW;

    localparam logic [DbW-1:0] DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HoldLast = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  RepLast  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPressed = 2'b01,
        StHeld    = 2'b10
    } state_e;

    state_e         state;
    logic [DbW-1:0] db_cnt;
    logic [HW-1:0]  hold_cnt;

    logic db_diff;
    logic db_done;
    logic rise;
    logic fall;

    assign db_diff = (sig_sync != btn_level);
    assign db_done = db_diff && (db_cnt == DbLast);
    assign rise    = db_done && !btn_level;
    assign fall    = db_done && btn_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            btn_level <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            repeat_p  <= 1'b0;
            long_hold <= 1'b0;
        end else begin
            if (!db_diff || db_done) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (db_done) begin
                btn_level <= ~btn_level;
            end

            press_p   <= rise;
            release_p <= fall;
            repeat_p  <= 1'b0;

            case (state)
                StIdle: begin
                    hold_cnt  <= '0;
                    long_hold <= 1'b0;
                    if (rise) begin
                        state <= StPressed;
                    end
                end
                StPressed: begin
                    if (fall) begin
                        state    <= StIdle;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HoldLast) begin
                        state     <= StHeld;
                        hold_cnt  <= '0;
                        repeat_p  <= 1'b1;
                        long_hold <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                StHeld: begin
                    // Release has priority over a coincident repeat expiry.
                    if (fall) begin
                        state     <= StIdle;
                        hold_cnt  <= '0;
                        long_hold <= 1'b0;
                    end else if (hold_cnt == RepLast) begin
                        hold_cnt  <= '0;
                        repeat_p  <= 1'b1;
                        long_hold <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + 1'b1;
                        long_hold <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    hold_cnt  <= '0;
                    long_hold <= 1'b0;
                    press_p   <= 1'b0;
                    release_p <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, multi-cycle corner cases,
// and random stimulus compared against an edge-counting reference model.
module tb_button_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic clk;
    logic rst_n;
    logic sig_sync;
    logic btn_level;
    logic press_p;
    logic release_p;
    logic repeat_p;
    logic long_hold;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_sync (sig_sync),
        .btn_level(btn_level),
        .press_p  (press_p),
        .release_p(release_p),
        .repeat_p (repeat_p),
        .long_hold(long_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sig;
        logic [4:0] exp;  // {level, press, release, repeat, long_hold}
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: level plus run length of disagreeing samples, and the
    // number of edges elapsed since the accepted press.
    logic m_lvl, m_press, m_rel, m_rep, m_long;
    int   m_run, m_t;

    task automatic model_reset();
        m_lvl = 0; m_press = 0; m_rel = 0; m_rep = 0; m_long = 0;
        m_run = 0; m_t = 0;
    endtask

    task automatic model_step();
        m_press = 0; m_rel = 0; m_rep = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (sig_sync != m_lvl) m_run++;
        else m_run = 0;
        if (m_run == DB) begin
            m_lvl = !m_lvl;
            m_run = 0;
            m_t   = 0;
            if (m_lvl) m_press = 1;
            else m_rel = 1;
        end else if (m_lvl) begin
            m_t++;
            if (m_t >= HOLD && ((m_t - HOLD) % REP) == 0) m_rep = 1;
        end
        m_long = m_lvl && (m_t >= HOLD);
    endtask

    task automatic check_out(input string tag, input logic [4:0] exp);
        logic [4:0] act;
        act = {btn_level, press_p, release_p, repeat_p, long_hold};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: lvl/press/rel/rep/long got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic tick(input logic s);
        sig_sync = s;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asynchronous reset for n edges; outputs must clear before any edge.
    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out("async_reset", 5'b0);
        for (int i = 0; i < n; i++) begin
            tick(sig_sync);
            check_out("in_reset", 5'b0);
        end
        rst_n = 1'b1;
    endtask

    logic [4:0] x;
    int         len;
    logic       lvl;

    initial begin
        rst_n    = 1'b0;
        sig_sync = 1'b0;
        model_reset();
        #3;
        check_out("reset", 5'b0);
        tick(1'b0);
        tick(1'b0);
        check_out("reset_held", 5'b0);
        rst_n = 1'b1;

        // Glitch (3 high samples) then clean press, hold and release.
        for (int e = 1; e <= 8; e++) vecs.push_back('{sig: (e <= 3), exp: 5'b0});
        for (int e = 1; e <= 30; e++) begin
            x[4] = (e >= 4 && e <= 23);
            x[3] = (e == 4);
            x[2] = (e == 24);
            x[1] = (e == 14 || e == 17 || e == 20 || e == 23);
            x[0] = (e >= 14 && e <= 23);
            vecs.push_back('{sig: (e <= 20), exp: x});
        end
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].sig);
            check_out($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Release debounce completes exactly on a repeat edge.
        for (int e = 1; e <= 30; e++) begin
            tick(e <= 22);
            if (e == 23) check_out("coll_rep23", 5'b10011);
            if (e == 25) check_out("coll_e25", 5'b10001);
            if (e == 26) check_out("coll_release_wins", 5'b00100);
            if (e == 27) check_out("coll_after", 5'b00000);
        end

        // Reset during hold with the button still pressed.
        for (int e = 1; e <= 15; e++) begin
            tick(1'b1);
            if (e == 14) check_out("mh_rep14", 5'b10011);
            if (e == 15) check_out("mh_e15", 5'b10001);
        end
        pulse_reset(2);
        for (int e = 18; e <= 25; e++) begin
            tick(1'b1);
            x = (e == 21) ? 5'b11000 : ((e < 21) ? 5'b00000 : 5'b10000);
            check_out($sformatf("mh_e%0d", e), x);
        end

        // Random runs of varying length against the reference model.
        pulse_reset(1);
        lvl = 1'b0;
        for (int r = 0; r < 400; r++) begin
            lvl = ~lvl;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 2));
                tick(lvl);
                check_out("rand", {m_lvl, m_press, m_rel, m_rep, m_long});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
